// File: rtl/addsub_serial.sv
// Serial add/subtract unit: CHUNK bits per cycle through a ripple chain of full-adder
// cells, with a start/busy/done handshake and Y86-style condition flags.
module addsub_serial #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             of,
  output logic             zf,
  output logic             sf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, op_q, op_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cf_q, cf_d, of_q, of_d, zf_q, zf_d, sf_q, sf_d;

  // One chunk of chained full-adder cells fed by the carry register.
  logic [CHUNK:0]   c;
  logic [CHUNK-1:0] s;

  assign c[0] = carry_q;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign s[gi]    = a_q[gi] ^ b_q[gi] ^ c[gi];
      assign c[gi+1]  = (a_q[gi] & b_q[gi]) | (c[gi] & (a_q[gi] ^ b_q[gi]));
    end
  endgenerate

  // Sum bits enter at the top so that after N chunks the register is LSB-aligned.
  logic [WIDTH-1:0] s_ext, sum_shift;
  assign s_ext     = WIDTH'(s);
  assign sum_shift = (sum_q >> CHUNK) | (s_ext << (WIDTH - CHUNK));

  logic accept, last_chunk;
  assign accept     = start && (state_q != RUN);
  assign last_chunk = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    cf_d     = cf_q;
    of_d     = of_q;
    zf_d     = zf_q;
    sf_d     = sf_q;

    if (accept) begin
      // Subtract is a + ~b + 1: invert b and seed the carry with op.
      state_d = RUN;
      a_d     = a;
      b_d     = op ? ~b : b;
      carry_d = op;
      op_d    = op;
      cnt_d   = '0;
      sum_d   = '0;
      busy_d  = 1'b1;
    end else if (state_q == RUN) begin
      a_d     = a_q >> CHUNK;
      b_d     = b_q >> CHUNK;
      sum_d   = sum_shift;
      carry_d = c[CHUNK];
      cnt_d   = cnt_q + CW'(1);
      if (last_chunk) begin
        state_d  = DONE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        cnt_d    = '0;
        result_d = sum_shift;
        cf_d     = c[CHUNK] ^ op_q;
        of_d     = c[CHUNK] ^ c[CHUNK-1];
        zf_d     = (sum_shift == '0);
        sf_d     = sum_shift[WIDTH-1];
      end
    end else begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      of_q     <= of_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cf     = cf_q;
  assign of     = of_q;
  assign zf     = zf_q;
  assign sf     = sf_q;

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Multi-cycle, parametrised add/subtract unit that processes CHUNK bits per clock through a ripple chain of 1-bit full-adder cells. It produces a WIDTH-bit result and Y86-style condition flags. It sits beside the sequential-processor ALU as the area-reduced successor of the single-bit full adder. It adds a start/busy/done handshake, subtract mode and flag generation, none of which the 1-bit cell has.

## Interface
Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK is the number of compute cycles.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only while busy=0.
- op  in  1  operation: 0 = add (a+b), 1 = subtract (a−b).
- a  in  WIDTH  first operand; sampled with start.
- b  in  WIDTH  second operand; sampled with start.
- busy  out  1  high while an operation is in progress (RUN state).
- done  out  1  one-cycle pulse; result and flags are valid from this cycle on.
- result  out  WIDTH  sum or difference; held until the next done.
- cf  out  1  add: carry out of the MSB; sub: borrow, i.e. the inverted carry out.
- of  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zf  out  1  result == 0.
- sf  out  1  result[WIDTH-1].

## Operation
- States are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE → RUN when start=1:
  - latch A=a and B = op ? ~b : b;
  - set carry register to op;
  - clear the chunk counter.
- RUN, each cycle:
  - add the lowest CHUNK bits of A and B plus the carry register through CHUNK chained full-adder cells;
  - shift A and B right by CHUNK;
  - shift the CHUNK sum bits into the top of the partial-sum register;
  - store the chunk's carry out;
  - increment the counter.
- On the last chunk (counter == N−1), capture the carry into the MSB cell and the carry out of the MSB cell.
- RUN → DONE after N compute cycles. On this transition the partial-sum register is copied to result and cf/of/zf/sf are updated.
- DONE → IDLE unconditionally after one cycle, with one exception: if start=1 in DONE, the unit goes directly to RUN with new operands (back-to-back).
- start is ignored while busy=1. Operands and op changing during RUN have no effect.
- result and flags change only on the RUN→DONE transition and on reset.
- Arithmetic is modulo 2^WIDTH. Two's-complement subtraction is computed as a + ~b + 1.
- CHUNK = WIDTH gives N=1, a single compute cycle.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state becomes IDLE;
  - busy=0, done=0, result=0, cf=0, of=0, zf=0, sf=0;
  - internal registers and counter are cleared.
- Reset takes priority over start and over any in-flight operation. Reset mid-RUN aborts the operation: no done pulse, outputs return to 0.
- Latency:
  - start is sampled at edge k; busy=1 from edge k.
  - compute edges are k+1 … k+N.
  - busy falls and done rises at edge k+N; done falls at edge k+N+1 unless a back-to-back start is accepted.
- Throughput: one operation per N+1 cycles with back-to-back starts.
- busy and done are never high in the same cycle.
- A start held high continuously launches a new operation every N+1 cycles.

## Test plan
1. WIDTH=8, CHUNK=2, add 0x7F+0x01:
   - done asserts exactly 4 edges after start is sampled;
   - result=0x80, of=1, sf=1, cf=0, zf=0.
2. WIDTH=8, CHUNK=2, add 0xFF+0x01 → result=0x00, cf=1, zf=1, of=0, sf=0.
3. WIDTH=8, CHUNK=2, sub:
   - 0x05−0x07 → result=0xFE, cf=1, sf=1, of=0;
   - then 0x80−0x01 → result=0x7F, of=1, cf=0, sf=0.
4. Pulse start again during RUN with different operands:
   - that start is ignored; the first result completes unchanged;
   - a start held high in DONE launches the next operation with no IDLE cycle.
5. Assert rst_n=0 for one cycle at the 2nd compute cycle:
   - no done pulse; all outputs read 0 at the following edge;
   - a subsequent add 0x10+0x20 gives 0x30.
6. Defaults (WIDTH=64, CHUNK=4):
   - random add/sub vectors checked against a behavioural model, including 0x7FFF_FFFF_FFFF_FFFF+1 (of=1, sf=1) and 0−0 sub (zf=1, cf=0);
   - done arrives 16 edges after start.
